// File: rtl/agnus_pkg.sv
// agnus_pkg: shared Agnus DMA channel numbering and a lowest-set-bit helper.
package agnus_pkg;

    typedef enum int {
        CH_DSK = 0,
        CH_REF = 1,
        CH_AUD = 2,
        CH_BPL = 3,
        CH_SPR = 4,
        CH_COP = 5,
        CH_BLT = 6,
        CH_NUM = 7
    } agnus_ch_e;

    localparam int MAX_CH = 16;

    // Isolates the lowest set bit (highest priority) as a one-hot vector.
    function automatic logic [MAX_CH-1:0] lowest_bit(input logic [MAX_CH-1:0] v);
        return v & (~v + 16'd1);
    endfunction

endpackage

// File: rtl/agnus_rr_pick.sv
// agnus_rr_pick: one-hot round-robin winner, first eligible at or after ptr, wrapping.
module agnus_rr_pick
    import agnus_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o
);

    logic [N-1:0] hi_v;

    // elig_i holds only group channels, so falling back to the lowest one wraps within the group.
    always_comb begin
        hi_v = '0;
        for (int i = 0; i < N; i++) hi_v[i] = elig_i[i] && (i >= int'(ptr_i));
        win_o = (|hi_v) ? N'(lowest_bit(MAX_CH'(hi_v))) : N'(lowest_bit(MAX_CH'(elig_i)));
    end

endmodule

// File: rtl/agnus_dma_arbiter.sv
// agnus_dma_arbiter: fixed-priority chip-bus DMA arbiter with optional round-robin tail
// group and a CPU-starvation throttle that masks selected channels.
module agnus_dma_arbiter
    import agnus_pkg::*;
#(
    parameter int             NCH      = 8,
    parameter int             AW       = 20,
    parameter int             RW       = 8,
    parameter int             RR_N     = 0,
    parameter logic [NCH-1:0] THR_MASK = NCH'(8'h80),
    parameter int             BLS_MAX  = 3,
    parameter int             CW       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk7_en,
    input  logic                     cck,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           ch_we,
    input  logic [NCH*AW-1:0]        ch_addr,
    input  logic [NCH*RW-1:0]        ch_reg,
    input  logic [RW-1:0]            cpu_reg,
    input  logic                     bls,
    input  logic                     nasty,
    output logic [NCH-1:0]           ack,
    output logic [$clog2(NCH)-1:0]   grant_idx,
    output logic [AW-1:0]            address_out,
    output logic [RW-1:0]            reg_address_out,
    output logic                     dbr,
    output logic                     dbwe,
    output logic                     cpu_custom,
    output logic                     throttled
);

    localparam int             IW       = $clog2(NCH);
    localparam int             FN       = NCH - RR_N;
    localparam logic [NCH-1:0] FIX_MASK = NCH'((32'd1 << FN) - 32'd1);

    logic [CW-1:0]  bls_cnt_q, bls_cnt_d;
    logic [NCH-1:0] elig, fix_oh, grp_oh;
    logic [RW-1:0]  ch_reg_sel;

    assign throttled = (bls_cnt_q == CW'(BLS_MAX));
    // Gating with reset keeps the bus released while reset is held, without waiting for a clock.
    assign elig      = req & ~(THR_MASK & {NCH{throttled}}) & {NCH{~reset}};
    assign fix_oh    = NCH'(lowest_bit(MAX_CH'(elig & FIX_MASK)));
    assign ack       = (|fix_oh) ? fix_oh : grp_oh;

    generate
        if (RR_N > 1) begin : g_rr
            logic [IW-1:0] rr_ptr_q, rr_ptr_d;
            agnus_rr_pick #(
                .N  (NCH),
                .IW (IW)
            ) u_pick (
                .elig_i (elig & ~FIX_MASK),
                .ptr_i  (rr_ptr_q),
                .win_o  (grp_oh)
            );
            assign rr_ptr_d = (int'(grant_idx) == NCH - 1) ? IW'(FN) : grant_idx + 1'b1;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) rr_ptr_q <= IW'(FN);
                else if (clk7_en && !(|fix_oh) && (|grp_oh)) rr_ptr_q <= rr_ptr_d;
            end
        end else begin : g_fix
            assign grp_oh = NCH'(lowest_bit(MAX_CH'(elig & ~FIX_MASK)));
        end
    endgenerate

    always_comb begin
        grant_idx   = '0;
        address_out = '0;
        ch_reg_sel  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ack[i]) begin
                grant_idx   = IW'(i);
                address_out = address_out | ch_addr[i*AW +: AW];
                ch_reg_sel  = ch_reg_sel | ch_reg[i*RW +: RW];
            end
        end
    end

    assign dbr             = |ack;
    assign dbwe            = |(ack & ch_we);
    assign cpu_custom      = ~dbr;
    assign reg_address_out = dbr ? ch_reg_sel : cpu_reg;

    // A clear request wins over an increment; the count saturates rather than wrapping.
    assign bls_cnt_d = (!bls || nasty) ? '0 : throttled ? bls_cnt_q : bls_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bls_cnt_q <= '0;
        else if (clk7_en && !cck) bls_cnt_q <= bls_cnt_d;
    end

endmodule

// File: tb/tb_agnus_dma_arbiter.sv
// tb_agnus_dma_arbiter: scoreboard bench for the DMA arbiter (RR_N=2, ch7 throttled).
module tb_agnus_dma_arbiter;

    localparam int NCH = 8;
    localparam int AW  = 20;
    localparam int RW  = 8;

    logic              clk = 1'b0, reset = 1'b1, clk7_en = 1'b0, cck = 1'b0;
    logic              bls = 1'b0, nasty = 1'b0;
    logic [NCH-1:0]    req = '0, ch_we = '0;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*RW-1:0] ch_reg;
    logic [RW-1:0]     cpu_reg = 8'hFF;
    logic [NCH-1:0]    ack;
    logic [2:0]        grant_idx;
    logic [AW-1:0]     address_out;
    logic [RW-1:0]     reg_address_out;
    logic              dbr, dbwe, cpu_custom, throttled;

    typedef struct packed {
        logic [7:0]  ack;
        logic [2:0]  idx;
        logic [19:0] addr;
        logic [7:0]  rg;
        logic        we;
        logic        thr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0, n_bad = 0, slot = 0;
    int   m_cnt, m_ptr, grp_j;
    logic [7:0] r, w, el, ea;
    logic en, c, b, n, thr;

    always #5 clk = ~clk;

    agnus_dma_arbiter #(
        .NCH(NCH), .AW(AW), .RW(RW), .RR_N(2), .THR_MASK(8'h80), .BLS_MAX(3), .CW(2)
    ) dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .cck(cck), .req(req), .ch_we(ch_we),
        .ch_addr(ch_addr), .ch_reg(ch_reg), .cpu_reg(cpu_reg), .bls(bls), .nasty(nasty),
        .ack(ack), .grant_idx(grant_idx), .address_out(address_out),
        .reg_address_out(reg_address_out), .dbr(dbr), .dbwe(dbwe),
        .cpu_custom(cpu_custom), .throttled(throttled)
    );

    function automatic logic [19:0] addr_of(input int i);
        return 20'hC0000 | 20'(i * 'h111);
    endfunction

    // Drives one bus slot and queues the outputs it must produce.
    task automatic step(input logic rst, input logic ven, input logic vc, input logic vb,
                        input logic vn, input logic [7:0] vr, input logic [7:0] vw,
                        input logic [7:0] cr, input logic [7:0] xa, input logic xt);
        exp_t e;
        @(negedge clk);
        reset = rst; clk7_en = ven; cck = vc; bls = vb; nasty = vn;
        req = vr; ch_we = vw; cpu_reg = cr;
        e.ack = xa; e.thr = xt; e.idx = '0; e.addr = '0; e.rg = cr; e.we = |(xa & vw);
        for (int i = 0; i < 8; i++)
            if (xa[i]) begin
                e.idx = 3'(i); e.addr = addr_of(i); e.rg = 8'h10 + 8'(i);
            end
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                slot++;
                n_cmp++;
                if ({ack, grant_idx, address_out, reg_address_out, dbwe, throttled} !== mon_e) begin
                    n_bad++;
                    $display("FAIL slot%0d {ack,idx,addr,reg,dbwe,thr} got %h required %h", slot,
                             {ack, grant_idx, address_out, reg_address_out, dbwe, throttled}, mon_e);
                end
                n_cmp++;
                if (!$onehot0(ack) || (dbwe && !dbr) || (cpu_custom !== ~dbr)) begin
                    n_bad++;
                    $display("FAIL slot%0d invariants got ack=%h dbr=%b dbwe=%b cpu_custom=%b required onehot0, dbwe->dbr, cpu_custom=~dbr",
                             slot, ack, dbr, dbwe, cpu_custom);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW] = addr_of(i);
            ch_reg[i*RW +: RW]  = 8'h10 + 8'(i);
        end
        // reset, fixed priority, idle CPU slot
        step(1, 1, 0, 0, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 0);
        step(0, 1, 0, 0, 0, 8'h60, 8'h20, 8'hFF, 8'h20, 0);
        step(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'hA5, 8'h00, 0);
        step(0, 1, 0, 0, 0, 8'h01, 8'h01, 8'hA5, 8'h01, 0);
        // round-robin group ch6/ch7
        step(0, 1, 0, 0, 0, 8'hC0, 8'h00, 8'hA5, 8'h40, 0);
        step(0, 1, 0, 0, 0, 8'hC0, 8'h00, 8'hA5, 8'h80, 0);
        step(0, 1, 0, 0, 0, 8'hC0, 8'h00, 8'hA5, 8'h40, 0);
        step(0, 1, 0, 0, 0, 8'hC0, 8'h00, 8'hA5, 8'h80, 0);
        step(0, 1, 0, 0, 0, 8'hC8, 8'h00, 8'hA5, 8'h08, 0);
        step(0, 1, 0, 0, 0, 8'hC0, 8'h00, 8'hA5, 8'h40, 0);
        step(0, 1, 0, 0, 0, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        // throttle engages after three cck=0 samples, releases when bls drops
        step(0, 1, 0, 1, 0, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        step(0, 1, 1, 1, 0, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        step(0, 1, 0, 1, 0, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        step(0, 1, 1, 1, 0, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        step(0, 1, 0, 1, 0, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        step(0, 1, 1, 1, 0, 8'h80, 8'h00, 8'hA5, 8'h00, 1);
        step(0, 1, 0, 1, 0, 8'h80, 8'h00, 8'hA5, 8'h00, 1);
        step(0, 1, 1, 1, 0, 8'hC0, 8'h00, 8'hA5, 8'h40, 1);
        step(0, 1, 0, 0, 0, 8'h80, 8'h00, 8'hA5, 8'h00, 1);
        step(0, 1, 1, 0, 0, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        // nasty holds the counter at zero
        for (int k = 0; k < 6; k++)
            step(0, 1, 1'(k % 2), 1, 1, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        // no enable, no counting
        for (int k = 0; k < 4; k++)
            step(0, 0, 0, 1, 0, 8'h80, 8'h00, 8'hA5, 8'h80, 0);
        // async reset mid-slot during a ch7 write grant
        step(0, 1, 0, 1, 0, 8'h40, 8'h00, 8'h3C, 8'h40, 0);
        step(0, 0, 0, 1, 0, 8'hC0, 8'hC0, 8'h3C, 8'h80, 0);
        step(1, 0, 0, 1, 0, 8'hC0, 8'hC0, 8'h3C, 8'h00, 0);
        step(0, 1, 0, 1, 0, 8'hC0, 8'h00, 8'h3C, 8'h40, 0);
        step(0, 1, 0, 1, 0, 8'h80, 8'h00, 8'h3C, 8'h80, 0);
        step(0, 1, 0, 1, 0, 8'h80, 8'h00, 8'h3C, 8'h80, 0);
        step(0, 1, 0, 1, 0, 8'h80, 8'h00, 8'h3C, 8'h00, 1);
        step(0, 1, 0, 0, 0, 8'h80, 8'h00, 8'h3C, 8'h00, 1);
        step(0, 1, 0, 0, 0, 8'h80, 8'h00, 8'h3C, 8'h80, 0);
        // random slots against a behavioural reference
        step(1, 1, 0, 0, 0, 8'hFF, 8'h00, 8'h77, 8'h00, 0);
        m_cnt = 0;
        m_ptr = 6;
        for (int k = 0; k < 400; k++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 1) == 1) r = r & 8'hC0;
            w = 8'($urandom);
            c = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) != 0);
            n = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 3) != 0);
            thr = (m_cnt == 3);
            el = thr ? (r & 8'h7F) : r;
            ea = '0;
            grp_j = -1;
            for (int i = 0; i < 6; i++)
                if (el[i] && ea == 0) ea[i] = 1'b1;
            if (ea == 0)
                for (int q = 0; q < 2; q++)
                    if (grp_j < 0 && el[6 + ((m_ptr - 6 + q) % 2)]) grp_j = 6 + ((m_ptr - 6 + q) % 2);
            if (grp_j >= 0) ea[grp_j] = 1'b1;
            step(0, en, c, b, n, r, w, 8'($urandom), ea, thr);
            if (en && grp_j >= 0) m_ptr = (grp_j == 7) ? 6 : grp_j + 1;
            if (en && !c) m_cnt = (!b || n) ? 0 : (m_cnt < 3 ? m_cnt + 1 : 3);
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending slots required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
